mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32, word width; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_WIDTH, default 9, word-address width.
REQ-003 Derived constant BE_WIDTH = DATA_WIDTH/8 SHALL set the byte-enable width.
REQ-004 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 resetn  in  1  asynchronous, active-low reset.
REQ-006 req_valid  in  1  requester presents a request.
REQ-007 req_ready  out  1  unit accepts a request this cycle.
REQ-008 req_we  in  1  1 = write, 0 = read.
REQ-009 req_addr  in  ADDR_WIDTH  word address.
REQ-010 req_wdata  in  DATA_WIDTH  write data.
REQ-011 req_be  in  BE_WIDTH  byte enables; bit i covers bits [8i+7:8i].
REQ-012 rsp_valid  out  1  one-cycle completion pulse, read or write.
REQ-013 rsp_rdata  out  DATA_WIDTH  read data, valid while rsp_valid=1 and the request was a read.
REQ-014 ram_addr  out  ADDR_WIDTH  to the synchronous single-port RAM, which registers its address.
REQ-015 ram_data  out  DATA_WIDTH  RAM write data.
REQ-016 ram_we  out  1  RAM write enable.
REQ-017 ram_q  in  DATA_WIDTH  RAM read data, valid the cycle after ram_addr is presented.

Function
REQ-018 Handshake: a request SHALL be accepted on a rising edge where req_valid=1 and req_ready=1; on acceptance, req_we, req_addr, req_wdata and req_be SHALL be captured into internal registers.
REQ-019 req_ready SHALL be 1 only in IDLE; at most one request SHALL be in flight; no response back-pressure exists.
REQ-020 FSM states: IDLE, ISSUE, CAPTURE, RESP.
REQ-021 IDLE -> ISSUE on acceptance; otherwise the FSM SHALL stay in IDLE.
REQ-022 In ISSUE, ram_addr SHALL equal the captured address and the next state SHALL be chosen as follows:
  - Write with all-ones be: ram_we=1, ram_data=captured wdata, next RESP.
  - Write with be=0: ram_we=0, next RESP (no-op, still acknowledged).
  - Read, or write with partial be: ram_we=0, next CAPTURE.
REQ-023 CAPTURE behaviour:
  - Read: rsp_rdata register <= ram_q, next RESP.
  - Partial write: ram_we=1; ram_data per byte = captured wdata byte if be bit is set, else ram_q byte; next RESP.
REQ-024 RESP SHALL assert rsp_valid for exactly one cycle and then go to IDLE.
REQ-025 rsp_rdata SHALL hold its last value outside read responses.
REQ-026 Latency from acceptance edge T: read response at T+3; full or empty-be write at T+2; partial write at T+3.
REQ-027 Back-to-back: the next request SHALL be acceptable in the cycle after rsp_valid, so read throughput is 1 per 4 cycles.
REQ-028 ram_we SHALL be 0 in IDLE and RESP; ram_addr SHALL hold the last captured address in IDLE.
REQ-029 A read issued after a write to the same address SHALL return the written data, with no bypass logic needed.
REQ-030 req_* inputs SHALL be ignored while req_ready=0.

Reset
REQ-031 resetn=0 SHALL immediately force state IDLE, req_ready=0, rsp_valid=0, ram_we=0, rsp_rdata=0, ram_addr=0, ram_data=0 and all captured registers to 0.
REQ-032 req_ready SHALL rise on the first clk edge after resetn deasserts.
REQ-033 Reset mid-operation SHALL abort the access: no rsp_valid and no further ram_we; a partial write aborted before CAPTURE SHALL leave memory unchanged.

Structure
REQ-034 Package mem_access_pkg SHALL hold the FSM state enum and the default DATA_WIDTH, ADDR_WIDTH and BE_WIDTH constants.
REQ-035 Combinational sub-module byte_merge (old word, new word, be -> merged word) SHALL implement the REQ-023 merge.
REQ-036 All outputs except rsp_rdata SHALL be decoded from the state and captured registers; no combinational path SHALL exist from req_* to ram_*.

Verification
REQ-037 Full write then read:
  - write addr 0x010, data 0xDEADBEEF, be 0xF -> ram_we pulse at T+1, rsp_valid at T+2;
  - read addr 0x010 -> rsp_rdata=0xDEADBEEF at T+3.
REQ-038 Partial write: memory at 0x020 = 0x11223344; write data 0xAABBCCDD, be 0x5 -> one ram_we at T+2, subsequent read returns 0x11BB33DD.
REQ-039 Empty be: write be 0x0 to 0x030 -> no ram_we, rsp_valid at T+2, memory unchanged.
REQ-040 Back-to-back: req_valid held high for 3 reads at 0x1FF, 0x000, 0x001 -> responses exactly 4 cycles apart, correct data, and address wrap at 0x1FF has no side effect.
REQ-041 Reset mid-op: assert resetn=0 in CAPTURE of a be=0x3 write -> no ram_we and no rsp_valid; req_ready=1 one edge after release; memory unchanged.
REQ-042 Protocol checker: rsp_valid never high for 2 consecutive cycles; ram_we never high in IDLE.

Source files
------------

// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared definitions for the memory access unit.
//   - default word / address / byte-enable widths
//   - FSM state encoding
package mem_access_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 9;
    localparam int DEF_BE_WIDTH   = DEF_DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_e;

endpackage

// File: rtl/mem_access_unit_byte_merge.sv
// byte_merge: combinational read-modify-write merge.
//   old_word : word currently in memory
//   new_word : requester write data
//   be       : byte enables, bit i selects new_word[8i+7:8i]
//   merged   : per byte, new byte where be is set, else old byte
module byte_merge
    import mem_access_pkg::*;
#(
    parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
    localparam int BE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic [DATA_WIDTH-1:0] old_word,
    input  logic [DATA_WIDTH-1:0] new_word,
    input  logic [BE_WIDTH-1:0]   be,
    output logic [DATA_WIDTH-1:0] merged
);

    for (genvar i = 0; i < BE_WIDTH; i++) begin : g_lane
        assign merged[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: single-outstanding request front end for a synchronous
// single-port RAM, with byte-enable writes done as read-modify-write.
//   clk, resetn          : clock, async active-low reset
//   req_valid/req_ready  : request handshake (ready only while idle)
//   req_we/addr/wdata/be : request fields, captured on acceptance
//   rsp_valid/rsp_rdata  : one-cycle completion pulse, read data register
//   ram_addr/data/we     : RAM port (RAM registers its address)
//   ram_q                : RAM read data, valid the cycle after ram_addr
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter  int ADDR_WIDTH = DEF_ADDR_WIDTH,
    localparam int BE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [BE_WIDTH-1:0]   req_be,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_q
);

    if (DATA_WIDTH % 8 != 0) begin : g_bad_width
        $error("mem_access_unit: DATA_WIDTH must be a multiple of 8");
    end

    state_e                state, state_nxt;
    logic                  rdy_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [BE_WIDTH-1:0]   be_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] merged;
    logic                  accept;
    logic                  be_full;
    logic                  be_none;

    assign accept  = req_valid && rdy_q;
    assign be_full = &be_q;
    assign be_none = ~|be_q;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = ISSUE;
            // Full and empty writes need no old data; everything else waits
            // one cycle for ram_q.
            ISSUE:   state_nxt = (we_q && (be_full || be_none)) ? RESP : CAPTURE;
            CAPTURE: state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            rdy_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_nxt;
            // Registered so ready stays low during reset and rises on the
            // first edge after release.
            rdy_q <= (state_nxt == IDLE);
            if (state == IDLE && accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                be_q    <= req_be;
            end
            if (state == CAPTURE && !we_q) rdata_q <= ram_q;
        end
    end

    byte_merge #(.DATA_WIDTH(DATA_WIDTH)) u_merge (
        .old_word (ram_q),
        .new_word (wdata_q),
        .be       (be_q),
        .merged   (merged)
    );

    // RAM side is decoded from state and captured fields only, never req_*.
    assign req_ready = rdy_q;
    assign rsp_valid = (state == RESP);
    assign rsp_rdata = rdata_q;
    assign ram_addr  = addr_q;
    assign ram_we    = we_q && ((state == ISSUE && be_full) || state == CAPTURE);
    assign ram_data  = (state == CAPTURE) ? merged : wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    localparam int DW = 32;
    localparam int AW = 9;
    localparam int BW = 4;

    logic          clk, resetn;
    logic          req_valid, req_ready, req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [BW-1:0] req_be;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data;
    logic          ram_we;
    logic [DW-1:0] ram_q;

    mem_access_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .ram_addr  (ram_addr),
        .ram_data  (ram_data),
        .ram_we    (ram_we),
        .ram_q     (ram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port RAM, read-before-write, registered address.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_data;
        ram_q <= mem[ram_addr];
    end

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [BW-1:0] be;
        int            lat;    // cycles from acceptance edge to rsp_valid sample
        int            nwe;    // number of ram_we cycles
        int            we_at;  // cycle of first ram_we
        logic [DW-1:0] exp;    // ram_data at write, or rsp_rdata for reads
    } vec_t;

    typedef struct {
        int            cyc;
        logic [DW-1:0] d;
    } rsp_t;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   we_cnt = 0;
    int   prot_err = 0;
    logic prev_rsp = 1'b0;
    rsp_t rsp_q[$];
    logic [DW-1:0] last_rd = '0;
    vec_t vec [14];
    logic [AW-1:0] b2b_addr [3];
    logic [DW-1:0] b2b_exp  [3];

    always @(posedge clk) cyc <= cyc + 1;

    // Response log plus protocol monitor (req_ready high means IDLE).
    always @(negedge clk) begin
        if (rsp_valid) rsp_q.push_back('{cyc: cyc, d: rsp_rdata});
        if (ram_we) we_cnt <= we_cnt + 1;
        prot_err <= prot_err + int'(rsp_valid && prev_rsp) + int'(ram_we && req_ready);
        prev_rsp <= rsp_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                                input logic [BW-1:0] be, input int lat, input int nwe,
                                input int we_at, input logic [DW-1:0] exp);
        vec_t v;
        v.we = we; v.addr = a; v.wdata = d; v.be = be;
        v.lat = lat; v.nwe = nwe; v.we_at = we_at; v.exp = exp;
        return v;
    endfunction

    task automatic do_req(input vec_t v, input int idx);
        int            n, lat, nwe, first_we;
        logic [AW-1:0] a1, wa;
        logic [DW-1:0] wd, rd;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        chk($sformatf("v%0d_ready", idx), 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata; req_be = v.be;
        @(posedge clk);
        #1;
        // Garbage on the request bus while busy must be ignored.
        req_valid = 1'b0; req_we = 1'b1; req_addr = '1; req_wdata = 32'h5A5A_5A5A; req_be = '1;
        lat = 0; nwe = 0; first_we = 0; a1 = '0; wa = '0; wd = '0; rd = '0;
        for (int k = 1; k <= 10 && lat == 0; k++) begin
            @(negedge clk);
            if (k == 1) a1 = ram_addr;
            if (ram_we) begin
                nwe++;
                if (first_we == 0) begin first_we = k; wa = ram_addr; wd = ram_data; end
            end
            if (rsp_valid) begin lat = k; rd = rsp_rdata; end
        end
        chk($sformatf("v%0d_issue_addr", idx), 32'(a1), 32'(v.addr));
        chk($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.lat));
        chk($sformatf("v%0d_we_count", idx), 32'(nwe), 32'(v.nwe));
        if (v.nwe > 0) begin
            chk($sformatf("v%0d_we_cycle", idx), 32'(first_we), 32'(v.we_at));
            chk($sformatf("v%0d_we_addr", idx), 32'(wa), 32'(v.addr));
            chk($sformatf("v%0d_we_data", idx), wd, v.exp);
        end
        if (!v.we) begin
            chk($sformatf("v%0d_rdata", idx), rd, v.exp);
            last_rd = v.exp;
        end else begin
            chk($sformatf("v%0d_rdata_hold", idx), rd, last_rd);
        end
        @(negedge clk);
        chk($sformatf("v%0d_ready_after", idx), 32'(req_ready), 32'd1);
    endtask

    initial begin
        int base, rsnap, wsnap, idx;
        resetn = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;

        vec[0]  = mk(1, 9'h010, 32'hDEADBEEF, 4'hF, 2, 1, 1, 32'hDEADBEEF);
        vec[1]  = mk(0, 9'h010, 32'h0,        4'h0, 3, 0, 0, 32'hDEADBEEF);
        vec[2]  = mk(1, 9'h020, 32'h11223344, 4'hF, 2, 1, 1, 32'h11223344);
        vec[3]  = mk(1, 9'h020, 32'hAABBCCDD, 4'h5, 3, 1, 2, 32'h11BB33DD);
        vec[4]  = mk(0, 9'h020, 32'h0,        4'h0, 3, 0, 0, 32'h11BB33DD);
        vec[5]  = mk(1, 9'h030, 32'hCAFEF00D, 4'hF, 2, 1, 1, 32'hCAFEF00D);
        vec[6]  = mk(1, 9'h030, 32'h12345678, 4'h0, 2, 0, 0, 32'h0);
        vec[7]  = mk(0, 9'h030, 32'h0,        4'h0, 3, 0, 0, 32'hCAFEF00D);
        vec[8]  = mk(1, 9'h1FF, 32'hA5A5A5A5, 4'hF, 2, 1, 1, 32'hA5A5A5A5);
        vec[9]  = mk(1, 9'h000, 32'h01020304, 4'hF, 2, 1, 1, 32'h01020304);
        vec[10] = mk(1, 9'h001, 32'h0BADF00D, 4'hF, 2, 1, 1, 32'h0BADF00D);
        vec[11] = mk(1, 9'h001, 32'hFFFFFFFF, 4'hA, 3, 1, 2, 32'hFFADFF0D);
        vec[12] = mk(0, 9'h001, 32'h0,        4'h0, 3, 0, 0, 32'hFFADFF0D);
        vec[13] = mk(1, 9'h040, 32'h55667788, 4'hF, 2, 1, 1, 32'h55667788);
        b2b_addr[0] = 9'h1FF; b2b_addr[1] = 9'h000; b2b_addr[2] = 9'h001;
        b2b_exp[0] = 32'hA5A5A5A5; b2b_exp[1] = 32'h01020304; b2b_exp[2] = 32'hFFADFF0D;

        // Reset state
        #1 resetn = 1'b0;
        #3;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_ram_we",    32'(ram_we),    32'd0);
        chk("rst_ram_addr",  32'(ram_addr),  32'd0);
        chk("rst_ram_data",  ram_data,       32'd0);
        chk("rst_rsp_rdata", rsp_rdata,      32'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        #1 chk("rst_ready_before_edge", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1 chk("rst_ready_first_edge", 32'(req_ready), 32'd1);

        for (int i = 0; i < 14; i++) do_req(vec[i], i);

        // Back-to-back reads with req_valid held high, including 0x1FF -> 0x000.
        base = rsp_q.size();
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_be = '0; req_wdata = '0; req_addr = b2b_addr[0];
        idx = 0;
        for (int c = 0; c < 40 && idx < 3; c++) begin
            if (req_ready) begin
                @(posedge clk);
                #1;
                idx++;
                if (idx < 3) req_addr = b2b_addr[idx];
                else req_valid = 1'b0;
            end
            @(negedge clk);
        end
        repeat (6) @(negedge clk);
        chk("b2b_count", 32'(rsp_q.size() - base), 32'd3);
        for (int i = 0; i < 3; i++)
            if (base + i < rsp_q.size()) chk($sformatf("b2b_data%0d", i), rsp_q[base+i].d, b2b_exp[i]);
        for (int i = 1; i < 3; i++)
            if (base + i < rsp_q.size())
                chk($sformatf("b2b_spacing%0d", i), 32'(rsp_q[base+i].cyc - rsp_q[base+i-1].cyc), 32'd4);
        last_rd = b2b_exp[2];

        // Reset while a be=0x3 write sits in CAPTURE.
        @(negedge clk);
        while (!req_ready) @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 9'h040; req_wdata = 32'h99AABBCC; req_be = 4'h3;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_in_capture_we", 32'(ram_we), 32'd1);
        rsnap = rsp_q.size(); wsnap = we_cnt;
        resetn = 1'b0;
        #1;
        chk("abort_ram_we",    32'(ram_we),    32'd0);
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort_req_ready", 32'(req_ready), 32'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        #1 chk("abort_ready_low", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1 chk("abort_ready_edge", 32'(req_ready), 32'd1);
        chk("abort_no_we",  32'(we_cnt), 32'(wsnap));
        chk("abort_no_rsp", 32'(rsp_q.size()), 32'(rsnap));
        last_rd = '0;
        do_req(mk(0, 9'h040, 32'h0, 4'h0, 3, 0, 0, 32'h55667788), 100);

        repeat (2) @(negedge clk);
        chk("protocol_violations", 32'(prot_err), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
